// File: rtl/pipelined_multiplier_if.sv
// rtl/pipelined_multiplier_if.sv - operand/result handshake bundle for pipelined_multiplier
//
// Purpose: carries the operation request stream (in_*), the result stream
// (out_*) and, when MULT_FLUSH_EN is defined, the flush request.
// Modports:
//   master - producer/consumer side (drives in_*, out_ready, flush)
//   slave  - multiplier side (drives in_ready, out_valid, out_result*, out_overflow, out_tag)
// Macro: MULT_FLUSH_EN adds the flush signal.
interface pipelined_multiplier_if #(
    parameter int DATA_LEN = 32,
    parameter int TAG_LEN  = 8
);
    logic                in_valid;
    logic                in_ready;
    logic                in_signed;
    logic [DATA_LEN-1:0] in_a;
    logic [DATA_LEN-1:0] in_b;
    logic [TAG_LEN-1:0]  in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_LEN-1:0] out_result;
    logic [DATA_LEN-1:0] out_result_hi;
    logic                out_overflow;
    logic [TAG_LEN-1:0]  out_tag;
`ifdef MULT_FLUSH_EN
    logic                flush;

    modport master (
        output in_valid, in_signed, in_a, in_b, in_tag, out_ready, flush,
        input  in_ready, out_valid, out_result, out_result_hi, out_overflow, out_tag
    );
    modport slave (
        input  in_valid, in_signed, in_a, in_b, in_tag, out_ready, flush,
        output in_ready, out_valid, out_result, out_result_hi, out_overflow, out_tag
    );
`else
    modport master (
        output in_valid, in_signed, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_result_hi, out_overflow, out_tag
    );
    modport slave (
        input  in_valid, in_signed, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_result_hi, out_overflow, out_tag
    );
`endif
endinterface

// File: rtl/pipelined_multiplier.sv
// rtl/pipelined_multiplier.sv - stallable pipelined signed/unsigned multiplier with tag sideband
//
// Purpose: accepts one operation per cycle (in_valid & in_ready), produces the
// full 2*DATA_LEN product split into out_result (low) / out_result_hi (high),
// an overflow flag for the selected mode and the operation's tag, exactly
// PIPELINE_STAGE register stages after acceptance.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-high reset; clears all valid bits and outputs
//   bus   - pipelined_multiplier_if.slave (in_* request stream, out_* result stream)
// Macro: MULT_FLUSH_EN - when defined, bus.flush synchronously drops every
//   in-flight operation and blocks acceptance for that cycle.
module pipelined_multiplier #(
    parameter int DATA_LEN       = 32,
    parameter int PIPELINE_STAGE = 2,
    parameter int TAG_LEN        = 8
) (
    input logic                   clk,
    input logic                   reset,
    pipelined_multiplier_if.slave bus
);
    localparam int PW   = 2 * DATA_LEN;
    localparam int LAST = PIPELINE_STAGE - 1;

    logic                flush_w;
    logic                stall;
    logic                accept;
    logic [PW-1:0]       a_ext;
    logic [PW-1:0]       b_ext;
    logic [PW-1:0]       prod_d;
    logic [DATA_LEN-1:0] lo_d;
    logic [DATA_LEN-1:0] hi_d;
    logic                ovf_d;

    logic [PIPELINE_STAGE-1:0] vld_q;
    logic [DATA_LEN-1:0]       lo_q  [PIPELINE_STAGE];
    logic [DATA_LEN-1:0]       hi_q  [PIPELINE_STAGE];
    logic                      ovf_q [PIPELINE_STAGE];
    logic [TAG_LEN-1:0]        tag_q [PIPELINE_STAGE];

`ifdef MULT_FLUSH_EN
    assign flush_w = bus.flush;
`else
    assign flush_w = 1'b0;
`endif

    // The whole pipe freezes while the last stage holds an untaken result;
    // bubbles are never squeezed out, so latency stays fixed.
    assign stall        = vld_q[LAST] && !bus.out_ready;
    assign bus.in_ready = !stall && !flush_w;
    assign accept       = bus.in_valid && bus.in_ready;

    // Extending both operands to 2*DATA_LEN per mode makes a single truncated
    // multiply correct for both signed and unsigned products.
    always_comb begin
        a_ext  = bus.in_signed ? {{DATA_LEN{bus.in_a[DATA_LEN-1]}}, bus.in_a}
                               : {{DATA_LEN{1'b0}}, bus.in_a};
        b_ext  = bus.in_signed ? {{DATA_LEN{bus.in_b[DATA_LEN-1]}}, bus.in_b}
                               : {{DATA_LEN{1'b0}}, bus.in_b};
        prod_d = a_ext * b_ext;
        lo_d   = prod_d[DATA_LEN-1:0];
        hi_d   = prod_d[PW-1:DATA_LEN];
        // Signed product fits only if the high half is pure sign extension.
        ovf_d  = bus.in_signed ? (hi_d != {DATA_LEN{lo_d[DATA_LEN-1]}})
                               : (hi_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < PIPELINE_STAGE; i++) begin
                lo_q[i]  <= '0;
                hi_q[i]  <= '0;
                ovf_q[i] <= 1'b0;
                tag_q[i] <= '0;
            end
        end else if (flush_w) begin
            // Only the valid bits drop; data registers keep their contents.
            vld_q <= '0;
        end else if (!stall) begin
            vld_q[0] <= accept;
            if (accept) begin
                lo_q[0]  <= lo_d;
                hi_q[0]  <= hi_d;
                ovf_q[0] <= ovf_d;
                tag_q[0] <= bus.in_tag;
            end
            for (int i = 1; i < PIPELINE_STAGE; i++) begin
                vld_q[i] <= vld_q[i-1];
                lo_q[i]  <= lo_q[i-1];
                hi_q[i]  <= hi_q[i-1];
                ovf_q[i] <= ovf_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign bus.out_valid     = vld_q[LAST];
    assign bus.out_result    = lo_q[LAST];
    assign bus.out_result_hi = hi_q[LAST];
    assign bus.out_overflow  = ovf_q[LAST];
    assign bus.out_tag       = tag_q[LAST];

endmodule
